// File: rtl/adc_store_pkg.sv
// ============================================================================
// adc_store_pkg : shared types and helpers for the ADC capture store
// Rev 1.0
// ============================================================================
`default_nettype none

package adc_store_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  // Bits needed to address n words, never less than one.
  function automatic int f_log2(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/adc_store_ram.sv
// ============================================================================
// adc_store_ram : NUM_WORDS x DATA_W simple dual-port buffer, 1-cycle read
// Rev 1.0
// ============================================================================
`default_nettype none

module adc_store_ram #(
  parameter int DATA_W    = 12,
  parameter int NUM_WORDS = 4,
  parameter int ADDR_W    = 2
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [NUM_WORDS];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  generate
    if ((1 << ADDR_W) == NUM_WORDS) begin : g_pow2
      always_ff @(posedge clk) begin
        if (i_re) r_rdata <= r_mem[i_raddr];
      end
    end else begin : g_npow2
      // Addresses past the last word read back as zero.
      localparam logic [ADDR_W:0] c_depth = (ADDR_W+1)'(NUM_WORDS);
      always_ff @(posedge clk) begin
        if (i_re) r_rdata <= ({1'b0, i_raddr} < c_depth) ? r_mem[i_raddr] : '0;
      end
    end
  endgenerate

  assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/adc_store_ctrl.sv
// ============================================================================
// adc_store_ctrl : arm/trigger capture sequencer and 2-reader RR read arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

module adc_store_ctrl
  import adc_store_pkg::*;
#(
  parameter  int DATA_W    = 12,
  parameter  int NUM_WORDS = 4,
  localparam int ADDR_W    = f_log2(NUM_WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic              abort,
  input  logic              trig,
  input  logic              adc_valid,
  input  logic [DATA_W-1:0] adc_data,
  input  logic [1:0]        rd_req,
  input  logic [ADDR_W-1:0] rd_addr0,
  input  logic [ADDR_W-1:0] rd_addr1,
  output logic [1:0]        rd_gnt,
  output logic              rd_valid,
  output logic              rd_id,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   wr_cnt
);

  localparam logic [ADDR_W:0] c_last = (ADDR_W+1)'(NUM_WORDS - 1);
  localparam logic [ADDR_W:0] c_one  = (ADDR_W+1)'(1);

  state_t              r_state;
  logic                r_busy;
  logic                r_done;
  logic [ADDR_W:0]     r_wr_cnt;
  logic                r_rr;
  logic                r_rd_valid;
  logic                r_rd_id;
  logic                w_we;
  logic [1:0]          w_gnt;
  logic [ADDR_W-1:0]   w_raddr;
  logic [DATA_W-1:0]   w_ram_q;

  // Abort drops the sample presented in the same cycle.
  always_comb begin
    w_we = 1'b0;
    if (!abort) begin
      case (r_state)
        ARMED:   w_we = trig & adc_valid;
        CAPTURE: w_we = adc_valid;
        default: w_we = 1'b0;
      endcase
    end
  end

  // r_rr=0 favours reader 0; it only moves when both readers contend.
  always_comb begin
    w_gnt = 2'b00;
    if (r_state == DONE && !arm) begin
      case (rd_req)
        2'b01:   w_gnt = 2'b01;
        2'b10:   w_gnt = 2'b10;
        2'b11:   w_gnt = r_rr ? 2'b10 : 2'b01;
        default: w_gnt = 2'b00;
      endcase
    end
  end

  assign w_raddr = w_gnt[1] ? rd_addr1 : rd_addr0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_wr_cnt <= '0;
    end else if (abort) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (arm) begin
            r_state  <= ARMED;
            r_busy   <= 1'b1;
            r_wr_cnt <= '0;
          end
        end
        ARMED: begin
          if (trig) begin
            r_state <= CAPTURE;
            if (adc_valid) r_wr_cnt <= r_wr_cnt + c_one;
          end
        end
        CAPTURE: begin
          if (adc_valid) begin
            r_wr_cnt <= r_wr_cnt + c_one;
            if (r_wr_cnt == c_last) begin
              r_state <= DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        DONE: begin
          if (arm) begin
            r_state  <= ARMED;
            r_busy   <= 1'b1;
            r_done   <= 1'b0;
            r_wr_cnt <= '0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_valid <= 1'b0;
      r_rd_id    <= 1'b0;
      r_rr       <= 1'b0;
    end else begin
      r_rd_valid <= |w_gnt;
      if (|w_gnt) r_rd_id <= w_gnt[1];
      if (rd_req == 2'b11 && |w_gnt) r_rr <= ~r_rr;
    end
  end

  adc_store_ram #(
    .DATA_W    (DATA_W),
    .NUM_WORDS (NUM_WORDS),
    .ADDR_W    (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_wr_cnt[ADDR_W-1:0]),
    .i_wdata (adc_data),
    .i_re    (|w_gnt),
    .i_raddr (w_raddr),
    .o_rdata (w_ram_q)
  );

  // The buffer itself is not reset, so its output is masked outside a read.
  assign rd_data  = r_rd_valid ? w_ram_q : '0;
  assign rd_gnt   = w_gnt;
  assign rd_valid = r_rd_valid;
  assign rd_id    = r_rd_id;
  assign busy     = r_busy;
  assign done     = r_done;
  assign wr_cnt   = r_wr_cnt;

endmodule

`default_nettype wire

// File: tb/tb_adc_store_ctrl.sv
// ============================================================================
// tb_adc_store_ctrl : directed stimulus with queued read expectations
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_adc_store_ctrl;

  logic        clk;
  logic        rst;
  logic        arm, abort, trig, adc_valid;
  logic [11:0] adc_data;
  logic [1:0]  rd_req;
  logic [1:0]  rd_addr0, rd_addr1;
  logic [1:0]  rd_gnt;
  logic        rd_valid, rd_id, busy, done;
  logic [11:0] rd_data;
  logic [2:0]  wr_cnt;

  logic        arm5, abort5, trig5, adc_valid5;
  logic [11:0] adc_data5;
  logic [1:0]  rd_req5;
  logic [2:0]  rd_addr05, rd_addr15;
  logic [1:0]  rd_gnt5;
  logic        rd_valid5, rd_id5, busy5, done5;
  logic [11:0] rd_data5;
  logic [3:0]  wr_cnt5;

  int checks   = 0;
  int failures = 0;
  logic [12:0] exp_q[$];

  adc_store_ctrl #(.DATA_W(12), .NUM_WORDS(4)) u_dut (
    .clk(clk), .rst(rst), .arm(arm), .abort(abort), .trig(trig),
    .adc_valid(adc_valid), .adc_data(adc_data), .rd_req(rd_req),
    .rd_addr0(rd_addr0), .rd_addr1(rd_addr1), .rd_gnt(rd_gnt),
    .rd_valid(rd_valid), .rd_id(rd_id), .rd_data(rd_data),
    .busy(busy), .done(done), .wr_cnt(wr_cnt)
  );

  adc_store_ctrl #(.DATA_W(12), .NUM_WORDS(5)) u_dut5 (
    .clk(clk), .rst(rst), .arm(arm5), .abort(abort5), .trig(trig5),
    .adc_valid(adc_valid5), .adc_data(adc_data5), .rd_req(rd_req5),
    .rd_addr0(rd_addr05), .rd_addr1(rd_addr15), .rd_gnt(rd_gnt5),
    .rd_valid(rd_valid5), .rd_id(rd_id5), .rd_data(rd_data5),
    .busy(busy5), .done(done5), .wr_cnt(wr_cnt5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every read response is popped against the queued expectation.
  always @(negedge clk) begin
    if (!rst && rd_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rd_unexpected actual=%0h required=none", {rd_id, rd_data});
      end else begin
        chk("rd_resp", 32'({rd_id, rd_data}), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic capture4(input logic [11:0] base);
    for (int i = 0; i < 4; i++) begin
      adc_valid = 1'b1;
      adc_data  = base + 12'(i);
      cyc();
    end
    adc_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; arm = 0; abort = 0; trig = 0; adc_valid = 0; adc_data = 0;
    rd_req = 0; rd_addr0 = 0; rd_addr1 = 0;
    arm5 = 0; abort5 = 0; trig5 = 0; adc_valid5 = 0; adc_data5 = 0;
    rd_req5 = 0; rd_addr05 = 0; rd_addr15 = 0;
    cyc(); cyc();
    rst = 1'b0;

    // Reset state
    chk("rst_gnt", 32'(rd_gnt), 0);
    chk("rst_valid", 32'(rd_valid), 0);
    chk("rst_data", 32'(rd_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_wrcnt", 32'(wr_cnt), 0);

    // 1: basic capture and reader-0 readout
    arm = 1; cyc(); arm = 0;
    chk("t1_busy_armed", 32'(busy), 1);
    trig = 1; cyc(); trig = 0;
    capture4(12'h101);
    chk("t1_done", 32'(done), 1);
    chk("t1_busy", 32'(busy), 0);
    chk("t1_wrcnt", 32'(wr_cnt), 4);
    for (int a = 0; a < 4; a++) begin
      rd_req = 2'b01; rd_addr0 = 2'(a);
      #1;
      chk("t1_gnt", 32'(rd_gnt), 32'h1);
      exp_q.push_back({1'b0, 12'h101 + 12'(a)});
      cyc();
      rd_req = 2'b00;
      chk("t1_latency", 32'(rd_valid), 1);
    end
    cyc();

    // 2: contention alternates
    rd_req = 2'b11; rd_addr0 = 2'd0; rd_addr1 = 2'd3;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t2_gnt", 32'(rd_gnt), (k % 2 == 1) ? 32'h2 : 32'h1);
      exp_q.push_back((k % 2 == 1) ? {1'b1, 12'h104} : {1'b0, 12'h101});
      cyc();
    end
    rd_req = 2'b00;
    cyc();

    // 3: adc_valid every other cycle
    arm = 1; cyc(); arm = 0;
    chk("t3_wrcnt_clr", 32'(wr_cnt), 0);
    trig = 1; cyc(); trig = 0;
    for (int i = 0; i < 8; i++) begin
      adc_valid = (i % 2 == 0);
      adc_data  = 12'h200 + 12'(i / 2);
      cyc();
      chk("t3_wrcnt", 32'(wr_cnt), 32'((i + 2) / 2));
      chk("t3_done", 32'(done), (i >= 6) ? 32'h1 : 32'h0);
    end
    adc_valid = 0;
    rd_req = 2'b10; rd_addr1 = 2'd2;
    exp_q.push_back({1'b1, 12'h202});
    cyc(); rd_req = 2'b00;
    cyc();

    // 4: trig in arm cycle ignored; trig with first valid gives word 0
    arm = 1; trig = 1; adc_valid = 1; adc_data = 12'h3FF;
    cyc();
    arm = 0; trig = 0; adc_data = 12'h3FE;
    cyc();
    chk("t4_still_armed", 32'(wr_cnt), 0);
    chk("t4_busy", 32'(busy), 1);
    trig = 1; adc_data = 12'h0AA;
    cyc();
    trig = 0;
    chk("t4_word0", 32'(wr_cnt), 1);
    for (int i = 0; i < 3; i++) begin
      adc_data = 12'h0AB + 12'(i);
      cyc();
    end
    adc_valid = 0;
    chk("t4_done", 32'(done), 1);
    rd_req = 2'b01; rd_addr0 = 2'd0;
    exp_q.push_back({1'b0, 12'h0AA});
    cyc();
    rd_addr0 = 2'd3;
    exp_q.push_back({1'b0, 12'h0AD});
    cyc(); rd_req = 2'b00;
    cyc();

    // 5: abort mid-capture, then reset mid-capture
    arm = 1; cyc(); arm = 0;
    trig = 1; adc_valid = 1; adc_data = 12'h500; cyc(); trig = 0;
    adc_data = 12'h501; cyc(); adc_valid = 0;
    chk("t5_wrcnt", 32'(wr_cnt), 2);
    abort = 1; cyc(); abort = 0;
    chk("t5_busy", 32'(busy), 0);
    chk("t5_done", 32'(done), 0);
    rd_req = 2'b01;
    #1;
    chk("t5_nogrant", 32'(rd_gnt), 0);
    cyc(); rd_req = 2'b00;
    chk("t5_novalid", 32'(rd_valid), 0);
    arm = 1; cyc(); arm = 0;
    trig = 1; adc_valid = 1; adc_data = 12'h510; cyc(); trig = 0;
    adc_data = 12'h511; cyc(); adc_valid = 0;
    rst = 1;
    #2;
    chk("t5_rst_busy", 32'(busy), 0);
    chk("t5_rst_wrcnt", 32'(wr_cnt), 0);
    chk("t5_rst_done", 32'(done), 0);
    chk("t5_rst_id", 32'(rd_id), 0);
    chk("t5_rst_valid", 32'(rd_valid), 0);
    cyc(); rst = 0;
    cyc();

    // 6: arm in DONE blocks the grant; an earlier read still completes
    arm = 1; cyc(); arm = 0;
    trig = 1; cyc(); trig = 0;
    capture4(12'h601);
    chk("t6_done", 32'(done), 1);
    rd_req = 2'b01; rd_addr0 = 2'd3;
    #1;
    chk("t6_gnt", 32'(rd_gnt), 32'h1);
    exp_q.push_back({1'b0, 12'h604});
    cyc();
    arm = 1; rd_addr0 = 2'd1;
    #1;
    chk("t6_blocked", 32'(rd_gnt), 0);
    cyc();
    arm = 0; rd_req = 2'b00;
    chk("t6_busy", 32'(busy), 1);
    chk("t6_done_clr", 32'(done), 0);
    chk("t6_wrcnt", 32'(wr_cnt), 0);
    chk("t6_novalid", 32'(rd_valid), 0);

    // Non-power-of-2 depth: out-of-range address reads zero
    arm5 = 1; cyc(); arm5 = 0;
    trig5 = 1; adc_valid5 = 1; adc_data5 = 12'h051; cyc(); trig5 = 0;
    for (int i = 0; i < 4; i++) begin
      adc_data5 = 12'h052 + 12'(i);
      cyc();
    end
    adc_valid5 = 0;
    chk("n5_done", 32'(done5), 1);
    chk("n5_wrcnt", 32'(wr_cnt5), 5);
    rd_req5 = 2'b01; rd_addr05 = 3'd6;
    cyc();
    chk("n5_oob_valid", 32'(rd_valid5), 1);
    chk("n5_oob_data", 32'(rd_data5), 0);
    rd_req5 = 2'b10; rd_addr15 = 3'd4;
    cyc();
    rd_req5 = 2'b00;
    chk("n5_last_data", 32'(rd_data5), 32'h055);
    chk("n5_last_id", 32'(rd_id5), 1);

    cyc(); cyc(); cyc();
    chk("sb_drain", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
